ndn_pipe: RTL and testbench
===========================

// Module: ndn_pipe
// PURPOSE
//  Parametrised, pipelined wide-gate reduction unit: N-input AND/NAND/OR/NOR built as a
//  registered tree of GROUP-input gates (an8 -> nd3 style), with valid/ready flow control.
//  Replaces fixed wide-gate instances on paths that need timing relief and qualification.
//  Also keeps a saturating count of true results. Sits between decode logic and consumers.
// PARAMETERS
//  WIDTH  10  number of inputs reduced (>=2)
//  GROUP  8   fan-in of each tree level (>=2)
//  CNT_W  16  width of true_cnt
//  LVL    derived: levels = ceil(log_GROUP(WIDTH)), min 1; one register per level
// PORTS
//  sys_clk    in   1        clock
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   1        a/mode valid
//  in_ready   out  1        unit accepts a/mode this cycle
//  a          in   WIDTH    operand vector
//  mode       in   2        00 AND, 01 NAND, 10 OR, 11 NOR (captured with a)
//  out_valid  out  1        q valid
//  out_ready  in   1        consumer takes q
//  q          out  1        reduction result
//  cnt_clr    in   1        clear true_cnt (and sticky_low)
//  true_cnt   out  CNT_W    saturating count of accepted results with q=1
// BEHAVIOUR
//  - Reset: all stage valids 0, out_valid=0, q=0, true_cnt=0; in-flight data dropped.
//  - Level k register holds ceil(partials/GROUP) partials + 1 valid + mode (travels with data).
//  - Padding: unused gate inputs tied to identity (1 for AND/NAND, 0 for OR/NOR).
//  - Inversion (NAND/NOR) applied only at the final level; intermediate levels true AND/OR.
//  - Latency: LVL cycles from accepted input to out_valid (WIDTH=10,GROUP=8: 2).
//  - Elastic pipeline: stage k loads when empty or stage k+1 loads/consumer takes;
//    in_ready = ~v0 | advance0 (combinational ready chain through all levels).
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - out_valid held, q stable while out_ready=0; no bubbles when out_ready=1 (1 result/clk).
//  - Full: LVL results stored with out_ready=0 -> in_ready=0.
//  - true_cnt: +1 on out transfer with q=1; saturates at 2^CNT_W-1 (no wrap).
//  - cnt_clr: true_cnt=0 next cycle; clr wins over simultaneous increment.
//  - Reset mid-operation: overrides everything, state as above next cycle.
// CONFIGURATION
//  NDN_STICKY_EN defined: extra output sticky_low (1 bit), reset 0; sets on out transfer
//    with q=0; clears on cnt_clr (clr wins over simultaneous set) or reset.
//  NDN_STICKY_EN undefined: port and its logic absent; all other behaviour identical.
// TESTING (defaults unless stated)
//  1. mode=00, a=0x3FF, out_ready=1 -> out_valid 2 cycles later, q=1, true_cnt=1.
//  2. mode=01: a=0x3FF -> q=0; a=0x1FF -> q=1; a=0x000 -> q=1; true_cnt=2.
//  3. mode=10 a=0x000 -> q=0; mode=11 a=0x000 -> q=1; mode=10 a=0x200 -> q=1.
//  4. out_ready=0, push 3 vectors -> 2 accepted, in_ready=0; out_ready=1 -> 3 results in order, back-to-back.
//  5. CNT_W=4, 17 true transfers -> true_cnt=15; cnt_clr with a true transfer -> 0.
//  6. reset with 2 in flight -> out_valid=0 next cycle, no result ever emerges; sticky_low=0 (if EN).

Source files
------------

// File: rtl/ndn_pipe.sv
// ---------------------------------------------------------------------------
// ndn_pipe -- pipelined wide-gate reduction unit
//
// Reduces WIDTH input bits to a single AND / NAND / OR / NOR result through a
// registered tree of GROUP-input gates. There is one register per tree level.
// The pipeline is elastic and uses valid/ready flow control. The unit also
// keeps a saturating count of results that leave the unit with q=1.
//
// Parameters
//   WIDTH  number of inputs reduced (>= 2)
//   GROUP  fan-in of each tree level (>= 2)
//   CNT_W  width of true_cnt
//   LVL    derived: ceil(log_GROUP(WIDTH)), minimum 1 (one register per level)
//
// Ports
//   sys_clk    in   1      clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      a/mode valid
//   in_ready   out  1      unit accepts a/mode this cycle
//   a          in   WIDTH  operand vector
//   mode       in   2      00 AND, 01 NAND, 10 OR, 11 NOR (captured with a)
//   out_valid  out  1      q valid
//   out_ready  in   1      consumer takes q
//   q          out  1      reduction result
//   cnt_clr    in   1      clear true_cnt (and sticky_low)
//   true_cnt   out  CNT_W  saturating count of delivered results with q=1
//   sticky_low out  1      only with NDN_STICKY_EN: set when a delivered q is 0
//
// Build option
//   NDN_STICKY_EN  when defined, adds the sticky_low output and its logic.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. This applies to in_valid/in_ready and to out_valid/out_ready.
// out_valid never drops and q never changes while out_ready is low. in_ready
// may depend combinationally on out_ready, because the ready signal ripples
// back through all levels.
// ---------------------------------------------------------------------------
module ndn_pipe #(
    parameter int WIDTH = 10,
    parameter int GROUP = 8,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             q,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] true_cnt
`ifdef NDN_STICKY_EN
    ,
    output logic             sticky_low
`endif
);

    // Returns the number of partial results present at the input of level lvl.
    // Level 0 sees WIDTH bits. Each level divides the count by GROUP,
    // rounding up.
    function automatic int parts(input int lvl);
        int n = WIDTH;
        for (int i = 0; i < lvl; i++) begin
            n = (n + GROUP - 1) / GROUP;
        end
        return n;
    endfunction

    // Returns the number of tree levels needed to reach a single bit.
    function automatic int calc_lvl();
        int n = WIDTH;
        int l = 0;
        for (int i = 0; i < 32; i++) begin
            if (n > 1) begin
                n = (n + GROUP - 1) / GROUP;
                l++;
            end
        end
        if (l < 1) l = 1;
        return l;
    endfunction

    // Returns the bit offset of level lvl's input inside the packed data chain.
    function automatic int offset(input int lvl);
        int s = 0;
        for (int i = 0; i < lvl; i++) begin
            s += parts(i);
        end
        return s;
    endfunction

    localparam int LVL     = calc_lvl();
    localparam int CHAIN_W = offset(LVL + 1);
    localparam int Q_OFF   = offset(LVL);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Each level's data is kept at its exact width, so the levels are packed
    // back to back in one vector. The slice at offset(k) is the input of
    // level k. The last slice is the single result bit.
    logic [CHAIN_W-1:0] data_chain;
    // Mode travels with its data. Slice k holds the mode seen by level k.
    logic [2*LVL-1:0]   mode_chain;
    // v_chain[0] is in_valid. v_chain[k+1] is the valid bit of level k.
    logic [LVL:0]       v_chain;
    // ld_chain[k] is high when level k loads this cycle.
    // ld_chain[LVL] is the consumer taking the result.
    logic [LVL:0]       ld_chain;

    assign data_chain[WIDTH-1:0] = a;
    assign mode_chain[1:0]       = mode;
    assign v_chain[0]            = in_valid;

    // Ready ripples backwards. A level can load when it is empty, or when
    // the level after it is loading (which frees this level).
    always_comb begin
        ld_chain      = '0;
        ld_chain[LVL] = out_ready;
        for (int k = LVL - 1; k >= 0; k--) begin
            ld_chain[k] = ~v_chain[k + 1] | ld_chain[k + 1];
        end
    end

    assign in_ready = ld_chain[0];

    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        localparam int  NIN  = parts(k);
        localparam int  NOUT = parts(k + 1);
        localparam int  PW   = NOUT * GROUP;
        localparam int  IOFF = offset(k);
        localparam int  OOFF = offset(k + 1);
        localparam bit  LAST = (k == LVL - 1);

        logic [NIN-1:0]  in_k;
        logic [1:0]      mode_k;
        logic [PW-1:0]   pad_k;
        logic [NOUT-1:0] data_d;
        logic [NOUT-1:0] data_q;
        logic            v_q;

        assign in_k   = data_chain[IOFF +: NIN];
        assign mode_k = mode_chain[2*k +: 2];

        // Gate inputs left over in the last group take the identity value
        // of the gate: 1 for AND, 0 for OR.
        // Intermediate levels compute true AND/OR only. The NAND/NOR
        // inversion is applied once, at the final level.
        always_comb begin
            pad_k          = {PW{~mode_k[1]}};
            pad_k[NIN-1:0] = in_k;
            data_d         = '0;
            for (int j = 0; j < NOUT; j++) begin
                if (mode_k[1]) begin
                    data_d[j] = |pad_k[j*GROUP +: GROUP];
                end else begin
                    data_d[j] = &pad_k[j*GROUP +: GROUP];
                end
            end
            if (LAST) begin
                data_d[0] = data_d[0] ^ mode_k[0];
            end
        end

        always_ff @(posedge sys_clk) begin
            if (reset) begin
                v_q    <= 1'b0;
                data_q <= '0;
            end else if (ld_chain[k]) begin
                v_q    <= v_chain[k];
                data_q <= data_d;
            end
        end

        assign v_chain[k + 1]          = v_q;
        assign data_chain[OOFF +: NOUT] = data_q;

        // After the last level, only the result bit is needed, so mode is
        // registered only between levels.
        if (k < LVL - 1) begin : g_mode
            logic [1:0] mode_q;

            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    mode_q <= 2'b00;
                end else if (ld_chain[k]) begin
                    mode_q <= mode_k;
                end
            end

            assign mode_chain[2*(k + 1) +: 2] = mode_q;
        end
    end

    assign out_valid = v_chain[LVL];
    assign q         = data_chain[Q_OFF];

    // ------------------------------------------------------------------
    // True-result counter. Clear has priority over a simultaneous
    // increment. The counter holds at all-ones instead of wrapping.
    // ------------------------------------------------------------------
    logic             xfer_out;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign xfer_out = out_valid & out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (xfer_out && q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign true_cnt = cnt_q;

`ifdef NDN_STICKY_EN
    // Records that a false result was delivered. Clear has priority over a
    // simultaneous set.
    logic sticky_q;
    logic sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (cnt_clr) begin
            sticky_d = 1'b0;
        end else if (xfer_out && !q) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_low = sticky_q;
`endif

endmodule

// File: tb/tb_ndn_pipe.sv
`timescale 1ns/1ps
module tb_ndn_pipe;
    localparam int W    = 10;
    localparam int G    = 8;
    localparam int CW   = 4;
    localparam int LVL  = 2;               // ceil(log8(10))
    localparam int CMAX = (1 << CW) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic          sys_clk   = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic          cnt_clr   = 1'b0;
    logic [W-1:0]  a         = '0;
    logic [1:0]    mode      = 2'b00;
    logic          in_ready;
    logic          out_valid;
    logic          q;
    logic [CW-1:0] true_cnt;
`ifdef NDN_STICKY_EN
    logic          sticky_low;
`endif

    int cyc    = 0;
    int n_vec  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    ndn_pipe #(.WIDTH(W), .GROUP(G), .CNT_W(CW)) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q        (q),
        .cnt_clr  (cnt_clr),
        .true_cnt (true_cnt)
`ifdef NDN_STICKY_EN
        ,
        .sticky_low(sticky_low)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each accepted input becomes an item that carries its final result and
    // the pipeline slot it occupies.
    // Timing rules:
    //   - An item moves forward when any slot ahead of it is free or the
    //     consumer is taking the result.
    //   - Input is accepted when a slot is free or the consumer is taking.
    typedef struct { logic res; int pos; } item_t;
    typedef struct { logic res; int cyc; } log_t;
    item_t mq[$];
    log_t  xlog[$];
    int    m_cnt  = 0;
    bit    m_stk  = 0;
    bit    m_init = 0;

    function automatic logic ref_result(input logic [W-1:0] v, input logic [1:0] m);
        logic r;
        r = m[1] ? (v != '0) : (v == {W{1'b1}});
        return r ^ m[0];
    endfunction

    task automatic model_step();
        bit    occ[LVL];
        bit    xfer;
        bit    acc;
        bit    fr;
        item_t it;
        log_t  le;
        if (reset) begin
            mq.delete();
            m_cnt  = 0;
            m_stk  = 0;
            m_init = 1;
            return;
        end
        if (!m_init) return;
        foreach (occ[i]) occ[i] = 0;
        foreach (mq[i]) occ[mq[i].pos] = 1;
        acc  = in_valid && ((mq.size() < LVL) || out_ready);
        xfer = (mq.size() > 0) && (mq[0].pos == LVL - 1) && out_ready;
        if (cnt_clr) begin
            m_cnt = 0;
            m_stk = 0;
        end
        if (xfer) begin
            if (!cnt_clr) begin
                if (mq[0].res) begin
                    if (m_cnt < CMAX) m_cnt++;
                end else begin
                    m_stk = 1;
                end
            end
            le.res = mq[0].res;
            le.cyc = cyc;
            xlog.push_back(le);
            void'(mq.pop_front());
        end
        foreach (mq[i]) begin
            if (mq[i].pos < LVL - 1) begin
                fr = out_ready;
                for (int s = mq[i].pos + 1; s < LVL; s++) if (!occ[s]) fr = 1;
                if (fr) mq[i].pos++;
            end
        end
        if (acc) begin
            it.res = ref_result(a, mode);
            it.pos = 0;
            mq.push_back(it);
        end
    endtask

    // Single compare process: outputs versus model, then advance the model
    // with the inputs the DUT will see at the coming edge.
    always @(negedge sys_clk) begin
        bit ev;
        bit er;
        if (m_init) begin
            ev = (mq.size() > 0) && (mq[0].pos == LVL - 1);
            er = (mq.size() < LVL) || out_ready;
            check("out_valid", out_valid, ev);
            check("in_ready", in_ready, er);
            check("true_cnt", true_cnt, m_cnt);
            if (ev) check("q", q, mq[0].res);
`ifdef NDN_STICKY_EN
            check("sticky_low", sticky_low, m_stk);
`endif
        end
        model_step();
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] av, input logic [1:0] mv);
        int n = 0;
        in_valid = 1'b1;
        a        = av;
        mode     = mv;
        @(negedge sys_clk);
        while (!in_ready && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 1, 0);
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    task automatic check_log3(input string nm, input logic e0, input logic e1, input logic e2);
        check({nm, "_n"}, xlog.size(), 3);
        if (xlog.size() == 3) begin
            check({nm, "_0"}, xlog[0].res, e0);
            check({nm, "_1"}, xlog[1].res, e1);
            check({nm, "_2"}, xlog[2].res, e2);
        end
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] oh;
        oh = '0;
        oh[$urandom_range(0, W - 1)] = 1'b1;
        case ($urandom_range(0, 4))
            0:       return {W{1'b1}};
            1:       return '0;
            2:       return W'($urandom);
            3:       return {W{1'b1}} ^ oh;
            default: return oh;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        bit took;
        logic [W-1:0] va[3];
        logic [1:0]   vm[3];

        // Reset state
        reset = 1'b1;
        step();
        step();
        @(negedge sys_clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q, 0);
        check("rst_cnt", true_cnt, 0);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;

        // 1: AND of all-ones, latency of 2
        xlog.delete();
        send(10'h3FF, 2'b00);
        @(negedge sys_clk);
        check("t1_ov_early", out_valid, 0);
        @(negedge sys_clk);
        check("t1_ov", out_valid, 1);
        check("t1_q", q, 1);
        @(negedge sys_clk);
        check("t1_cnt", true_cnt, 1);
        step();
        check("t1_log_n", xlog.size(), 1);

        // 2: NAND
        pulse_clr();
        xlog.delete();
        send(10'h3FF, 2'b01);
        send(10'h1FF, 2'b01);
        send(10'h000, 2'b01);
        repeat (4) step();
        check_log3("t2", 1'b0, 1'b1, 1'b1);
        check("t2_cnt", true_cnt, 2);

        // 3: OR / NOR
        pulse_clr();
        xlog.delete();
        send(10'h000, 2'b10);
        send(10'h000, 2'b11);
        send(10'h200, 2'b10);
        repeat (4) step();
        check_log3("t3", 1'b0, 1'b1, 1'b1);

        // 4: fill with consumer stalled, then drain back-to-back
        va[0] = 10'h3FF; vm[0] = 2'b00;
        va[1] = 10'h000; vm[1] = 2'b11;
        va[2] = 10'h001; vm[2] = 2'b00;
        xlog.delete();
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        a         = va[0];
        mode      = vm[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            took = in_ready;
            step();
            if (took) begin
                acc++;
                if (acc < 3) begin
                    a    = va[acc];
                    mode = vm[acc];
                end
            end
        end
        check("t4_accepted", acc, 2);
        @(negedge sys_clk);
        check("t4_full_ready", in_ready, 0);
        step();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            took = in_ready;
            step();
            if (took) begin
                in_valid = 1'b0;
                break;
            end
        end
        repeat (5) step();
        check_log3("t4", 1'b1, 1'b1, 1'b0);
        if (xlog.size() == 3) begin
            check("t4_b2b_1", xlog[1].cyc - xlog[0].cyc, 1);
            check("t4_b2b_2", xlog[2].cyc - xlog[1].cyc, 1);
        end

        // 5: saturation, then clear colliding with a true transfer
        pulse_clr();
        for (int i = 0; i < 17; i++) send(10'h3FF, 2'b00);
        repeat (4) step();
        check("t5_sat", true_cnt, 15);
        send(10'h3FF, 2'b00);
        step();
        cnt_clr = 1'b1;          // covers the edge where the result transfers
        step();
        cnt_clr = 1'b0;
        @(negedge sys_clk);
        check("t5_clr_wins", true_cnt, 0);
        step();

        // 6: reset with two results in flight
        out_ready = 1'b0;
        send(10'h3FF, 2'b00);
        send(10'h000, 2'b01);
        xlog.delete();
        reset = 1'b1;
        step();
        @(negedge sys_clk);
        check("t6_ov", out_valid, 0);
`ifdef NDN_STICKY_EN
        check("t6_sticky", sticky_low, 0);
`endif
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        check("t6_nothing_out", xlog.size(), 0);
        check("t6_cnt", true_cnt, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = rand_vec();
            mode      = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr   = ($urandom_range(0, 40) == 0);
            reset     = ($urandom_range(0, 300) == 0);
            step();
        end
        in_valid  = 1'b0;
        cnt_clr   = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
